// File: rtl/reg_file_sb_pkg.sv
// Shared types for the architectural register file: entry layout, flag vector, register ids.
// Pure declarations and helpers, no timing or backpressure of its own.
package reg_file_sb_pkg;

  localparam int REG_FILE_SIZE = 20;
  localparam int FLAGS_IDX     = 16;
  localparam int REG_DATA_W    = 64;
  localparam int REG_IDX_W     = $clog2(REG_FILE_SIZE);

  // Bit order {cf,zf,sf,of,pf,af}, matching the flag fields of reg_val_t.
  typedef logic [5:0] flags_t;

  typedef struct packed {
    logic [REG_DATA_W-1:0] val;
    logic                  cf;
    logic                  zf;
    logic                  sf;
    logic                  of;
    logic                  pf;
    logic                  af;
  } reg_val_t;

  typedef enum logic [REG_IDX_W-1:0] {
    REG_RAX, REG_RCX, REG_RDX, REG_RBX, REG_RSP, REG_RBP, REG_RSI, REG_RDI,
    REG_R8,  REG_R9,  REG_R10, REG_R11, REG_R12, REG_R13, REG_R14, REG_R15,
    REG_RFLAGS, REG_RIP, REG_TMP0, REG_TMP1
  } reg_id_t;

  function automatic logic [REG_IDX_W-1:0] reg_num(input reg_id_t id);
    return REG_IDX_W'(id);
  endfunction

  function automatic reg_val_t pack_reg(input logic [REG_DATA_W-1:0] v, input flags_t f);
    reg_val_t r;
    r.val = v;
    {r.cf, r.zf, r.sf, r.of, r.pf, r.af} = f;
    return r;
  endfunction

  function automatic flags_t reg_flags(input reg_val_t r);
    return {r.cf, r.zf, r.sf, r.of, r.pf, r.af};
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Issue/writeback bundle for reg_file_sb: read ports, reservation handshake, writeback ports.
// master = core pipeline side, slave = register file side.
interface reg_file_sb_if #(
  parameter int NRD    = 4,
  parameter int NWR    = 2,
  parameter int IDX_W  = 5,
  parameter int DATA_W = 64
);
  import reg_file_sb_pkg::*;

  logic [NRD-1:0][IDX_W-1:0]  rd_idx;
  reg_val_t [NRD-1:0]         rd_val;
  logic [NRD-1:0]             rd_busy;

  logic                       rsv_valid;
  logic [IDX_W-1:0]           rsv_idx;
  logic                       rsv_ready;

  logic [NWR-1:0]             wr_valid;
  logic [NWR-1:0][IDX_W-1:0]  wr_idx;
  logic [NWR-1:0][DATA_W-1:0] wr_val;
  logic [NWR-1:0]             wr_flags_en;
  flags_t [NWR-1:0]           wr_flags;
  logic [NWR-1:0]             wr_release;

  logic                       flush;
  logic                       err;

  modport master (
    output rd_idx, rsv_valid, rsv_idx, wr_valid, wr_idx, wr_val,
           wr_flags_en, wr_flags, wr_release, flush,
    input  rd_val, rd_busy, rsv_ready, err
  );

  modport slave (
    input  rd_idx, rsv_valid, rsv_idx, wr_valid, wr_idx, wr_val,
           wr_flags_en, wr_flags, wr_release, flush,
    output rd_val, rd_busy, rsv_ready, err
  );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Busy-bit scoreboard: reservations set, writeback releases clear, flush wipes; sticky protocol error.
// rsv_ready is combinational from registered busy state; a refused request must be held by issue.
module reg_scoreboard #(
  parameter int NREGS = 20,
  parameter int NRD   = 4,
  parameter int NWR   = 2,
  parameter int IDX_W = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NRD-1:0][IDX_W-1:0] i_rd_idx,
  output logic [NRD-1:0]            o_rd_busy,
  input  logic                      i_rsv_valid,
  input  logic [IDX_W-1:0]          i_rsv_idx,
  output logic                      o_rsv_ready,
  input  logic [NWR-1:0]            i_wr_valid,
  input  logic [NWR-1:0][IDX_W-1:0] i_wr_idx,
  input  logic [NWR-1:0]            i_wr_release,
  input  logic                      i_flush,
  output logic                      o_err
);

  localparam logic [IDX_W:0] IDX_LIM = (IDX_W+1)'(NREGS);

  logic [NREGS-1:0] r_busy;
  logic             r_err;
  logic [NREGS-1:0] w_rsv_mask;
  logic [NREGS-1:0] w_rel_mask;
  logic [NREGS-1:0] w_busy_nxt;
  logic             w_rsv_in;
  logic             w_rsv_busy;
  logic             w_err_set;

  always_comb begin
    for (int r = 0; r < NRD; r++) begin
      o_rd_busy[r] = 1'b0;
      for (int e = 0; e < NREGS; e++) begin
        if (i_rd_idx[r] == IDX_W'(e)) o_rd_busy[r] = r_busy[e];
      end
    end
  end

  always_comb begin
    w_rsv_in   = ({1'b0, i_rsv_idx} < IDX_LIM);
    w_rsv_busy = 1'b0;
    for (int e = 0; e < NREGS; e++) begin
      if (i_rsv_idx == IDX_W'(e)) w_rsv_busy = r_busy[e];
    end
    o_rsv_ready = i_rsv_valid & w_rsv_in & ~w_rsv_busy & ~i_flush;

    w_rsv_mask = '0;
    for (int e = 0; e < NREGS; e++) begin
      if (o_rsv_ready && i_rsv_idx == IDX_W'(e)) w_rsv_mask[e] = 1'b1;
    end

    // A release only counts alongside a valid, in-range writeback.
    w_err_set  = i_rsv_valid & ~w_rsv_in;
    w_rel_mask = '0;
    for (int p = 0; p < NWR; p++) begin
      if (i_wr_valid[p]) begin
        if ({1'b0, i_wr_idx[p]} >= IDX_LIM) begin
          w_err_set = 1'b1;
        end else if (i_wr_release[p]) begin
          for (int e = 0; e < NREGS; e++) begin
            if (i_wr_idx[p] == IDX_W'(e)) begin
              w_rel_mask[e] = 1'b1;
              if (!r_busy[e]) w_err_set = 1'b1;
            end
          end
        end
      end
    end

    // Reservation is applied after release so a same-cycle pair leaves the bit set.
    w_busy_nxt = i_flush ? '0 : ((r_busy & ~w_rel_mask) | w_rsv_mask);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_err  <= r_err | w_err_set;
    end
  end

  assign o_err = r_err;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with NRD combinational read ports (0-cycle, same-cycle write bypass) and NWR writeback ports.
// Writes never stall and land on the next edge; only reservations push back, through rsv_ready.
module reg_file_sb #(
  parameter int NREGS     = reg_file_sb_pkg::REG_FILE_SIZE,
  parameter int NRD       = 4,
  parameter int NWR       = 2,
  parameter int DATA_W    = reg_file_sb_pkg::REG_DATA_W,
  parameter int FLAGS_IDX = reg_file_sb_pkg::FLAGS_IDX,
  parameter int IDX_W     = $clog2(NREGS)
) (
  input  logic         clk,
  input  logic         reset_n,
  reg_file_sb_if.slave bus
);
  import reg_file_sb_pkg::*;

  localparam logic [IDX_W:0]   IDX_LIM  = (IDX_W+1)'(NREGS);
  localparam logic [IDX_W-1:0] FLAG_ENT = IDX_W'(FLAGS_IDX);

  // Only entry FLAGS_IDX can ever hold non-zero flags, so a single flag register backs it.
  logic [DATA_W-1:0] r_vals [NREGS];
  flags_t            r_flags;
  logic [NWR-1:0]    w_wr_ok;
  logic [DATA_W-1:0] w_rd_v [NRD];
  flags_t            w_rd_f [NRD];

  // An out-of-range writeback is dropped as a whole, including its flag update.
  always_comb begin
    for (int p = 0; p < NWR; p++) begin
      w_wr_ok[p] = bus.wr_valid[p] & ({1'b0, bus.wr_idx[p]} < IDX_LIM);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < NREGS; e++) r_vals[e] <= '0;
      r_flags <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        for (int e = 0; e < NREGS; e++) begin
          if (w_wr_ok[p] && bus.wr_idx[p] == IDX_W'(e)) r_vals[e] <= bus.wr_val[p];
        end
        if (w_wr_ok[p] && bus.wr_flags_en[p]) r_flags <= bus.wr_flags[p];
      end
    end
  end

  // Ascending port scan matches the storage loop, so the highest port wins in both.
  always_comb begin
    for (int r = 0; r < NRD; r++) begin
      w_rd_v[r] = '0;
      w_rd_f[r] = '0;
      for (int e = 0; e < NREGS; e++) begin
        if (bus.rd_idx[r] == IDX_W'(e)) w_rd_v[r] = r_vals[e];
      end
      if (bus.rd_idx[r] == FLAG_ENT) w_rd_f[r] = r_flags;
      for (int p = 0; p < NWR; p++) begin
        if (w_wr_ok[p] && bus.wr_idx[p] == bus.rd_idx[r]) w_rd_v[r] = bus.wr_val[p];
        if (w_wr_ok[p] && bus.wr_flags_en[p] && bus.rd_idx[r] == FLAG_ENT) w_rd_f[r] = bus.wr_flags[p];
      end
      bus.rd_val[r] = pack_reg(w_rd_v[r], w_rd_f[r]);
    end
  end

  reg_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR),
    .IDX_W (IDX_W)
  ) u_sb (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_rd_idx     (bus.rd_idx),
    .o_rd_busy    (bus.rd_busy),
    .i_rsv_valid  (bus.rsv_valid),
    .i_rsv_idx    (bus.rsv_idx),
    .o_rsv_ready  (bus.rsv_ready),
    .i_wr_valid   (bus.wr_valid),
    .i_wr_idx     (bus.wr_idx),
    .i_wr_release (bus.wr_release),
    .i_flush      (bus.flush),
    .o_err        (bus.err)
  );

endmodule
